// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory stage: FSM state encoding,
// write-back source select codes and the MEM/WB record.
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  // Write-back source select carried on mem_to_reg.
  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC4 = 2'b10
  } mem_to_reg_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register; loads every cycle, a bubble clears only reg_write
// so no architectural write can leak from a stalled slot.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_bubble,
  input  mem_wb_t i_data,
  output mem_wb_t o_data
);

  mem_wb_t r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      r_data <= i_data;
      if (i_bubble) begin
        r_data.reg_write <= 1'b0;
      end
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: word-wide data-memory handshake with wait-state stall,
// bounded wait timeout, fetch redirect and the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_reg_write,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_mem_write,
  input  logic [1:0]  ex_mem_mem_to_reg,
  input  logic        ex_mem_jump,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_rdata2,
  input  logic [4:0]  ex_mem_rd,
  input  logic [31:0] ex_mem_pc_plus4,
  input  logic        ex_mem_branch_taken,
  input  logic [31:0] ex_mem_branch_target,
  input  logic [31:0] ex_mem_jump_target,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_target,
  output logic        mem_wb_reg_write,
  output logic [1:0]  mem_wb_mem_to_reg,
  output logic [31:0] mem_wb_alu_result,
  output logic [31:0] mem_wb_mem_rdata,
  output logic [31:0] mem_wb_pc_plus4,
  output logic [4:0]  mem_wb_rd,
  output logic        dmem_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e    r_state;
  logic [CW-1:0] r_wait_cnt;

  logic    w_op;
  logic    w_busy;
  logic    w_timeout;
  logic    w_complete;
  logic    w_load;
  logic    w_stall;
  mem_wb_t w_wb_next;
  mem_wb_t w_wb_q;

  assign w_op       = ex_mem_mem_read | ex_mem_mem_write;
  assign w_load     = ex_mem_mem_read & ~ex_mem_mem_write;
  assign w_busy     = (r_state == ST_BUSY);
  // A ready arriving on the last permitted cycle beats the timeout.
  assign w_timeout  = w_busy & w_op & ~dmem_ready &
                      (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_complete = w_op & dmem_ready;
  assign w_stall    = w_op & ~dmem_ready & ~w_timeout;

  assign dmem_req     = w_op;
  assign dmem_we      = ex_mem_mem_write;
  assign dmem_addr    = {ex_mem_alu_result[31:2], 2'b00};
  assign dmem_wdata   = ex_mem_rdata2;
  assign mem_stall    = w_stall;
  assign dmem_timeout = w_timeout;

  assign pc_redirect        = (ex_mem_branch_taken | ex_mem_jump) & ~w_stall;
  assign pc_redirect_target = ex_mem_jump ? ex_mem_jump_target : ex_mem_branch_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_stall) begin
            r_state    <= ST_BUSY;
            r_wait_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (w_stall) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_wb_next            = '0;
    w_wb_next.reg_write  = ex_mem_reg_write;
    w_wb_next.mem_to_reg = ex_mem_mem_to_reg;
    w_wb_next.alu_result = ex_mem_alu_result;
    w_wb_next.mem_rdata  = (w_complete & w_load) ? dmem_rdata : '0;
    w_wb_next.pc_plus4   = ex_mem_pc_plus4;
    w_wb_next.rd         = ex_mem_rd;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (w_stall),
    .i_data   (w_wb_next),
    .o_data   (w_wb_q)
  );

  assign mem_wb_reg_write  = w_wb_q.reg_write;
  assign mem_wb_mem_to_reg = w_wb_q.mem_to_reg;
  assign mem_wb_alu_result = w_wb_q.alu_result;
  assign mem_wb_mem_rdata  = w_wb_q.mem_rdata;
  assign mem_wb_pc_plus4   = w_wb_q.pc_plus4;
  assign mem_wb_rd         = w_wb_q.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// instructions scored against a per-instruction timing/data model.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  typedef struct {
    bit          rd_en;
    bit          wr_en;
    bit          reg_write;
    bit [1:0]    mtr;
    bit          jump;
    bit          bt;
    bit [31:0]   alu;
    bit [31:0]   wd;
    bit [31:0]   pc4;
    bit [31:0]   btgt;
    bit [31:0]   jtgt;
    bit [31:0]   rdat;
    bit [4:0]    rd;
    int unsigned waits;
  } instr_t;

  logic        clk;
  logic        rst;
  logic        ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
  logic [1:0]  ex_mem_mem_to_reg;
  logic        ex_mem_jump, ex_mem_branch_taken;
  logic [31:0] ex_mem_alu_result, ex_mem_rdata2, ex_mem_pc_plus4;
  logic [31:0] ex_mem_branch_target, ex_mem_jump_target;
  logic [4:0]  ex_mem_rd;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, pc_redirect, dmem_timeout;
  logic [31:0] pc_redirect_target;
  logic        mem_wb_reg_write;
  logic [1:0]  mem_wb_mem_to_reg;
  logic [31:0] mem_wb_alu_result, mem_wb_mem_rdata, mem_wb_pc_plus4;
  logic [4:0]  mem_wb_rd;

  int unsigned n_checks;
  int unsigned n_err;
  instr_t      t;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ex_mem_reg_write     (ex_mem_reg_write),
    .ex_mem_mem_read      (ex_mem_mem_read),
    .ex_mem_mem_write     (ex_mem_mem_write),
    .ex_mem_mem_to_reg    (ex_mem_mem_to_reg),
    .ex_mem_jump          (ex_mem_jump),
    .ex_mem_alu_result    (ex_mem_alu_result),
    .ex_mem_rdata2        (ex_mem_rdata2),
    .ex_mem_rd            (ex_mem_rd),
    .ex_mem_pc_plus4      (ex_mem_pc_plus4),
    .ex_mem_branch_taken  (ex_mem_branch_taken),
    .ex_mem_branch_target (ex_mem_branch_target),
    .ex_mem_jump_target   (ex_mem_jump_target),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_ready           (dmem_ready),
    .dmem_rdata           (dmem_rdata),
    .mem_stall            (mem_stall),
    .pc_redirect          (pc_redirect),
    .pc_redirect_target   (pc_redirect_target),
    .mem_wb_reg_write     (mem_wb_reg_write),
    .mem_wb_mem_to_reg    (mem_wb_mem_to_reg),
    .mem_wb_alu_result    (mem_wb_alu_result),
    .mem_wb_mem_rdata     (mem_wb_mem_rdata),
    .mem_wb_pc_plus4      (mem_wb_pc_plus4),
    .mem_wb_rd            (mem_wb_rd),
    .dmem_timeout         (dmem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input instr_t x);
    ex_mem_reg_write     = x.reg_write;
    ex_mem_mem_read      = x.rd_en;
    ex_mem_mem_write     = x.wr_en;
    ex_mem_mem_to_reg    = x.mtr;
    ex_mem_jump          = x.jump;
    ex_mem_branch_taken  = x.bt;
    ex_mem_alu_result    = x.alu;
    ex_mem_rdata2        = x.wd;
    ex_mem_rd            = x.rd;
    ex_mem_pc_plus4      = x.pc4;
    ex_mem_branch_target = x.btgt;
    ex_mem_jump_target   = x.jtgt;
  endtask

  task automatic check_wb_zero(input string pfx);
    chk({pfx, "_wb_rw"},   32'(mem_wb_reg_write), 32'd0);
    chk({pfx, "_wb_mtr"},  32'(mem_wb_mem_to_reg), 32'd0);
    chk({pfx, "_wb_alu"},  mem_wb_alu_result, 32'd0);
    chk({pfx, "_wb_rdat"}, mem_wb_mem_rdata, 32'd0);
    chk({pfx, "_wb_pc4"},  mem_wb_pc_plus4, 32'd0);
    chk({pfx, "_wb_rd"},   32'(mem_wb_rd), 32'd0);
  endtask

  // Model: an op with N wait cycles finishes in cycle min(N, TO) (0-based);
  // it times out only when N exceeds TO, and a timed-out load returns zero.
  task automatic run_instr(input instr_t x);
    bit          op, load, tmo, last, redir;
    int unsigned last_c;
    op     = x.rd_en | x.wr_en;
    load   = x.rd_en & ~x.wr_en;
    last_c = !op ? 0 : (x.waits < TO ? x.waits : TO);
    tmo    = op && (x.waits > TO);
    apply(x);
    for (int unsigned c = 0; c <= TO; c++) begin
      @(negedge clk);
      dmem_ready = op ? (c == x.waits) : 1'($urandom_range(0, 1));
      dmem_rdata = (op && c == x.waits) ? x.rdat : $urandom;
      #1;
      last  = (c == last_c);
      redir = (x.jump | x.bt) & last;
      chk("stall", 32'(mem_stall), 32'(!last));
      chk("req",   32'(dmem_req), 32'(op));
      chk("tmo",   32'(dmem_timeout), 32'(tmo && last));
      chk("redir", 32'(pc_redirect), 32'(redir));
      if (redir) chk("redir_tgt", pc_redirect_target, x.jump ? x.jtgt : x.btgt);
      if (op) begin
        chk("addr",  dmem_addr, {x.alu[31:2], 2'b00});
        chk("we",    32'(dmem_we), 32'(x.wr_en));
        chk("wdata", dmem_wdata, x.wd);
      end
      @(posedge clk);
      #1;
      if (!last) begin
        chk("bubble_rw", 32'(mem_wb_reg_write), 32'd0);
      end else begin
        chk("wb_rw",   32'(mem_wb_reg_write), 32'(x.reg_write));
        chk("wb_mtr",  32'(mem_wb_mem_to_reg), 32'(x.mtr));
        chk("wb_alu",  mem_wb_alu_result, x.alu);
        chk("wb_rdat", mem_wb_mem_rdata, (load && !tmo) ? x.rdat : 32'd0);
        chk("wb_pc4",  mem_wb_pc_plus4, x.pc4);
        chk("wb_rd",   32'(mem_wb_rd), 32'(x.rd));
        break;
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    t          = '{default: 0};
    apply(t);
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    rst        = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_wb_zero("reset");
    chk("reset_tmo",   32'(dmem_timeout), 32'd0);
    chk("reset_req",   32'(dmem_req), 32'd0);
    chk("reset_stall", 32'(mem_stall), 32'd0);
    rst = 1'b0;

    // Zero-wait load of x5 from 0x100.
    t = '{default: 0};
    t.rd_en = 1; t.reg_write = 1; t.mtr = 2'b01; t.rd = 5'd5;
    t.alu = 32'h100; t.pc4 = 32'h44; t.rdat = 32'hDEADBEEF; t.waits = 0;
    run_instr(t);

    // Store to an unaligned address with three wait states.
    t = '{default: 0};
    t.wr_en = 1; t.alu = 32'h203; t.wd = 32'h12345678; t.pc4 = 32'h48;
    t.rd = 5'd9; t.waits = 3;
    run_instr(t);

    // Load that never sees ready: timeout, zero data.
    t = '{default: 0};
    t.rd_en = 1; t.reg_write = 1; t.mtr = 2'b01; t.rd = 5'd7;
    t.alu = 32'h180; t.rdat = 32'hCAFEF00D; t.waits = 50;
    run_instr(t);

    // Ready on the very cycle the timeout would fire.
    t.waits = TO; t.rdat = 32'hA5A55A5A;
    run_instr(t);

    // Stalled load followed by a jump, then a taken branch.
    t = '{default: 0};
    t.rd_en = 1; t.reg_write = 1; t.mtr = 2'b01; t.rd = 5'd3;
    t.alu = 32'h40; t.rdat = 32'h0BADF00D; t.waits = 2;
    run_instr(t);
    t = '{default: 0};
    t.jump = 1; t.reg_write = 1; t.mtr = 2'b10; t.rd = 5'd1;
    t.pc4 = 32'h5C; t.jtgt = 32'h400; t.btgt = 32'h999;
    run_instr(t);
    t = '{default: 0};
    t.bt = 1; t.btgt = 32'h800; t.jtgt = 32'h123;
    run_instr(t);

    // Read and write both set behaves as a store.
    t = '{default: 0};
    t.rd_en = 1; t.wr_en = 1; t.alu = 32'h2FF; t.wd = 32'h55AA55AA;
    t.rdat = 32'hFFFFFFFF; t.waits = 1;
    run_instr(t);

    // Reset during the second BUSY cycle abandons the access.
    t = '{default: 0};
    t.rd_en = 1; t.reg_write = 1; t.mtr = 2'b01; t.rd = 5'd12;
    t.alu = 32'h300; t.pc4 = 32'h70;
    apply(t);
    @(negedge clk); dmem_ready = 1'b0; #1;
    chk("rst_idle_stall", 32'(mem_stall), 32'd1);
    @(negedge clk); #1;
    chk("rst_busy1_stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    t = '{default: 0};
    apply(t);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_req",   32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_tmo",   32'(dmem_timeout), 32'd0);
    check_wb_zero("rst_busy");

    t = '{default: 0};
    t.rd_en = 1; t.reg_write = 1; t.mtr = 2'b01; t.rd = 5'd14;
    t.alu = 32'h304; t.rdat = 32'h13579BDF; t.waits = 1;
    run_instr(t);

    for (int i = 0; i < 60; i++) begin
      int unsigned kind;
      kind        = $urandom_range(0, 3);
      t           = '{default: 0};
      t.rd_en     = (kind == 1) || (kind == 3);
      t.wr_en     = (kind == 2) || (kind == 3);
      t.reg_write = 1'($urandom_range(0, 1));
      t.mtr       = 2'($urandom_range(0, 2));
      t.jump      = ($urandom_range(0, 4) == 0);
      t.bt        = ($urandom_range(0, 4) == 0);
      t.alu       = $urandom;
      t.wd        = $urandom;
      t.pc4       = $urandom;
      t.btgt      = $urandom;
      t.jtgt      = $urandom;
      t.rdat      = $urandom;
      t.rd        = 5'($urandom_range(0, 31));
      t.waits     = $urandom_range(0, TO + 2);
      run_instr(t);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have EX/MEM inputs: ex_mem_reg_write 1, ex_mem_mem_read 1, ex_mem_mem_write 1, ex_mem_mem_to_reg 2, ex_mem_jump 1, ex_mem_alu_result 32, ex_mem_rdata2 32, ex_mem_rd 5, ex_mem_pc_plus4 32, ex_mem_branch_taken 1, ex_mem_branch_target 32, ex_mem_jump_target 32.
REQ-004 SHALL have data-memory port: dmem_req out 1; dmem_we out 1; dmem_addr out 32; dmem_wdata out 32; dmem_ready in 1 (access complete); dmem_rdata in 32 (valid with dmem_ready on reads).
REQ-005 SHALL have: mem_stall out 1, holds EX/MEM and all upstream stages.
REQ-006 SHALL have: pc_redirect out 1 and pc_redirect_target out 32, redirect request to fetch.
REQ-007 SHALL have MEM/WB outputs: mem_wb_reg_write 1, mem_wb_mem_to_reg 2, mem_wb_alu_result 32, mem_wb_mem_rdata 32, mem_wb_pc_plus4 32, mem_wb_rd 5.
REQ-008 SHALL have: dmem_timeout out 1, one-cycle pulse on aborted access.
REQ-009 SHALL have parameter TIMEOUT_CYCLES, default 255, max wait cycles in BUSY.

Function
REQ-010 Memory op present = ex_mem_mem_read | ex_mem_mem_write; both set SHALL be treated as write.
REQ-011 dmem_addr SHALL be {ex_mem_alu_result[31:2],2'b00}; dmem_wdata = ex_mem_rdata2; dmem_we = ex_mem_mem_write; word accesses only.
REQ-012 FSM states IDLE, BUSY.
REQ-013 IDLE, op present: dmem_req=1 combinationally same cycle; dmem_ready=1 -> complete same cycle, no stall, stay IDLE; dmem_ready=0 -> mem_stall=1, next state BUSY.
REQ-014 BUSY: dmem_req=1, dmem_addr/we/wdata stable; mem_stall=1 until dmem_ready=1; ready cycle: mem_stall=0, complete, next IDLE.
REQ-015 BUSY wait counter SHALL clear on IDLE->BUSY, increment each BUSY cycle without ready; reaching TIMEOUT_CYCLES: abort, dmem_timeout=1 one cycle, mem_stall=0, load data = 0, next IDLE.
REQ-016 No op present: dmem_req=0, mem_stall=0, state IDLE.
REQ-017 MEM/WB register SHALL load on every rising edge: mem_stall=0 -> EX/MEM fields, mem_wb_mem_rdata = dmem_rdata on completed read else 0; mem_stall=1 -> bubble (mem_wb_reg_write=0, other fields don't-care).
REQ-018 Latency: zero-wait access 1 cycle EX/MEM to MEM/WB; N-wait access N+1 cycles.
REQ-019 pc_redirect SHALL be (ex_mem_branch_taken | ex_mem_jump) & ~mem_stall, combinational; target = jump_target when ex_mem_jump else branch_target; asserted exactly once per instruction.
REQ-020 dmem_ready outside a request SHALL be ignored.
REQ-021 Simultaneous dmem_ready and timeout: ready wins, no dmem_timeout pulse.

Reset
REQ-022 rst SHALL force: state IDLE, wait counter 0, mem_wb_reg_write 0, mem_wb_rd 0, mem_wb_mem_to_reg 0, all 32-bit MEM/WB outputs 0, dmem_timeout 0.
REQ-023 rst in BUSY SHALL abandon the access; dmem_req low from the first post-reset cycle unless a new op is present.

Structure
REQ-024 Shared pipeline definitions package SHALL hold the FSM state encoding, mem_to_reg codes (00 ALU, 01 MEM, 10 PC+4), default TIMEOUT_CYCLES.
REQ-025 MEM/WB register SHALL be a separate sub-module mem_wb_reg with bubble-on-stall input.

Verification
REQ-026 Load x5 from 0x100, dmem_ready tied 1, rdata 0xDEADBEEF -> no stall, next cycle mem_wb_mem_rdata=0xDEADBEEF, mem_wb_rd=5, mem_wb_reg_write=1.
REQ-027 Store 0x12345678 to 0x203, ready after 3 waits -> dmem_addr=0x200 held 4 cycles, mem_stall=1 for 3 cycles, 3 bubbles then store in MEM/WB with reg_write=0.
REQ-028 TIMEOUT_CYCLES=4, ready never -> dmem_timeout pulses once at 4th BUSY cycle, stall released, mem_wb_mem_rdata=0.
REQ-029 Jump (target 0x400) behind stalled load -> pc_redirect only once the jump sits unstalled in MEM, 1 cycle, target 0x400; branch-taken case gives branch_target.
REQ-030 rst in 2nd BUSY cycle -> dmem_req=0, all MEM/WB outputs 0 next cycle; fresh load then completes normally.
